arith_unit_mc: RTL and testbench
================================

Name: arith_unit_mc

Overview:
Parametrised, multi-cycle signed arithmetic unit. Successor to the single-cycle registered ALU arithmetic slice.
- ADD/SUB complete in one cycle.
- MUL and DIV run on an iterative shift engine (one bit per cycle) instead of a combinational multiplier/divider.
- Operands and results use a valid/ready handshake; a result is held until consumed. Explicit overflow and divide-by-zero flags.
- Sits between the ALU operand decoder and the ALU output mux.

Parameters:
WIDTH, 16, operand width in bits (signed, two's complement); legal range 4..64.

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
in_valid  in  1  operand/opcode valid
in_ready  out  1  unit can accept an operation
A  in  WIDTH  signed operand A (dividend)
B  in  WIDTH  signed operand B (divisor)
op  in  2  00 ADD, 01 SUB, 10 MUL, 11 DIV
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
result  out  2*WIDTH  signed result; DIV packs {remainder, quotient}
ovf  out  1  overflow flag, qualified by out_valid
dz  out  1  divide-by-zero flag, qualified by out_valid

Behaviour:
Reset (rst=0, asynchronous):
- State goes to IDLE. in_ready=1 after reset release.
- out_valid=0, result=0, ovf=0, dz=0.
- Reset mid-operation aborts the operation; no partial result ever appears.

States:
- IDLE: in_ready=1. On in_valid, capture A, B and op.
  - ADD/SUB → DONE.
  - MUL → BUSY.
  - DIV with B≠0 → BUSY.
  - DIV with B=0 → DONE.
- BUSY: in_ready=0. Iteration counter loads WIDTH-1 on accept and decrements each cycle. After WIDTH iterations → FIX.
- FIX: apply sign correction to the magnitude result → DONE.
- DONE: out_valid=1, in_ready=0. result, ovf and dz are stable. When out_ready=1, go to IDLE and drop out_valid on the next edge.

Latency, from the accept edge to the first cycle with out_valid=1:
- ADD/SUB, and DIV by zero: 1 cycle.
- MUL/DIV: WIDTH+2 cycles (WIDTH BUSY + FIX + DONE entry).

Handshake rules:
- No new accept while out_valid=1; in_ready is high only in IDLE.
- in_valid/op/A/B are ignored outside IDLE.
- out_ready while out_valid=0 has no effect.

Arithmetic:
- ADD/SUB: exact (WIDTH+1)-bit result, sign-extended to 2*WIDTH. ovf=1 when the result does not fit in WIDTH signed bits.
- MUL: magnitude shift-add of |A|·|B|, negated in FIX if sign(A)^sign(B). Full 2*WIDTH product, ovf=0.
- DIV:
  - Restoring division on |A|, |B|.
  - Quotient truncates toward zero; remainder takes the sign of A.
  - result[WIDTH-1:0]=Q, result[2*WIDTH-1:WIDTH]=R.
- DIV boundary cases:
  - B=0: Q=0, R=A, dz=1, ovf=0.
  - A=-2^(WIDTH-1), B=-1: Q=-2^(WIDTH-1) (wrapped), R=0, ovf=1.
- Magnitude of -2^(WIDTH-1) is computed in WIDTH+1 bits; no internal wrap.

Decomposition:
- Package arith_mc_pkg:
  - op constants OP_ADD/OP_SUB/OP_MUL/OP_DIV.
  - state enum IDLE/BUSY/FIX/DONE.
- Sub-module seq_muldiv_core:
  - Iterative unsigned shift-add multiplier / restoring divider.
  - Ports: start, mode, magnitudes, done, product/quotient/remainder.
  - Top owns the handshake, sign handling, flags and special cases.

Test Plan (WIDTH=16):
- ADD A=32767, B=1, out_ready=1 → out_valid 1 cycle after accept, result=0x0000_8000, ovf=1, dz=0.
- MUL A=-3, B=7 → out_valid exactly 18 cycles after accept, result=0xFFFF_FFEB, ovf=0; in_ready=0 throughout.
- DIV A=-7, B=2 → Q=0xFFFD (-3), R=0xFFFF (-1), result=0xFFFF_FFFD after 18 cycles. Also DIV A=-32768, B=-1 → result=0x0000_8000, ovf=1.
- DIV A=5, B=0 → 1-cycle latency, result=0x0005_0000, dz=1, ovf=0.
- Backpressure: SUB 10-3 with out_ready=0 for 5 cycles → result=0x0000_0007 and out_valid held stable. in_valid pulses with other ops during the hold are ignored. Accept resumes only after the out_ready handshake.
- Reset: assert rst low at BUSY cycle 8 of a MUL → out_valid=0, result=0 immediately. After release in_ready=1, and a following ADD 2+2 yields 0x0000_0004.

Source files
------------

// File: rtl/arith_mc_pkg.sv
// Shared opcode constants and FSM state encoding for the multi-cycle arithmetic unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package arith_mc_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } state_t;

endpackage

// File: rtl/seq_muldiv_core.sv
// Iterative unsigned engine: shift-add multiply or restoring divide, one bit per cycle.
// Latency: WIDTH cycles after start; done is high during the final iteration cycle.
// Backpressure: none; the caller must hold the results until it has consumed them.
module seq_muldiv_core #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               mode,       // 0 = multiply, 1 = divide
  input  logic [WIDTH-1:0]   mag_a,      // multiplier / dividend magnitude
  input  logic [WIDTH-1:0]   mag_b,      // multiplicand / divisor magnitude
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder
);

  localparam int CW = $clog2(WIDTH);

  // hi/lo form one shift register: {partial product, multiplier} or {remainder, dividend/quotient}
  logic             busy;
  logic             mode_q;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] hi, lo, opb;
  logic [WIDTH-1:0] hi_nxt, lo_nxt;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_sub;
  logic             div_fits;

  assign done      = busy && (cnt == '0);
  assign product   = {hi, lo};
  assign quotient  = lo;
  assign remainder = hi;

  // One iteration step for whichever operation is in flight
  always_comb begin
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opb} : '0);
    div_shift = {hi, lo[WIDTH-1]};
    div_sub   = div_shift - {1'b0, opb};
    div_fits  = (div_shift >= {1'b0, opb});
    hi_nxt    = hi;
    lo_nxt    = lo;
    if (!mode_q) begin
      hi_nxt = mul_sum[WIDTH:1];
      lo_nxt = {mul_sum[0], lo[WIDTH-1:1]};
    end else if (div_fits) begin
      hi_nxt = WIDTH'(div_sub);
      lo_nxt = {lo[WIDTH-2:0], 1'b1};
    end else begin
      hi_nxt = WIDTH'(div_shift);
      lo_nxt = {lo[WIDTH-2:0], 1'b0};
    end
  end

  // Load operands on start, then iterate WIDTH times with a down-counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy   <= 1'b0;
      mode_q <= 1'b0;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      opb    <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      mode_q <= mode;
      cnt    <= CW'(WIDTH - 1);
      hi     <= '0;
      lo     <= mag_a;
      opb    <= mag_b;
    end else if (busy) begin
      hi  <= hi_nxt;
      lo  <= lo_nxt;
      cnt <= cnt - 1'b1;
      if (cnt == '0) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/arith_unit_mc.sv
// Multi-cycle signed ADD/SUB/MUL/DIV with valid/ready handshake and overflow/div-by-zero flags.
// Latency: 1 cycle for ADD/SUB and DIV by zero; WIDTH+2 cycles for MUL/DIV.
// Backpressure: result held in DONE until out_ready; in_ready only while IDLE.
module arith_unit_mc
  import arith_mc_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [1:0]         op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               ovf,
  output logic               dz
);

  state_t state, state_nxt;

  logic               accept, start;
  logic               core_done;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   quotient, remainder;
  logic [WIDTH-1:0]   quo_s, rem_s;

  logic [WIDTH:0]     a_ext, b_ext, sum_ext;
  logic [WIDTH:0]     abs_a, abs_b;
  logic               b_zero, div_wrap;

  logic [1:0]         op_q;
  logic               neg_q, sa_q;
  logic [2*WIDTH-1:0] result_q;
  logic               ovf_q, dz_q;

  // Operands widened by one bit so both the sum and |-2^(WIDTH-1)| are exact
  assign a_ext    = {A[WIDTH-1], A};
  assign b_ext    = {B[WIDTH-1], B};
  assign sum_ext  = (op == OP_SUB) ? (a_ext - b_ext) : (a_ext + b_ext);
  assign abs_a    = A[WIDTH-1] ? (~a_ext + 1'b1) : a_ext;
  assign abs_b    = B[WIDTH-1] ? (~b_ext + 1'b1) : b_ext;
  assign b_zero   = (B == '0);
  assign div_wrap = (A == {1'b1, {(WIDTH-1){1'b0}}}) && (B == '1);
  assign accept   = in_ready && in_valid;

  // Sign correction of the magnitude quotient/remainder
  assign quo_s = neg_q ? (~quotient + 1'b1) : quotient;
  assign rem_s = sa_q ? (~remainder + 1'b1) : remainder;

  assign result = result_q;
  assign ovf    = ovf_q;
  assign dz     = dz_q;

  seq_muldiv_core #(.WIDTH(WIDTH)) u_core (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (op == OP_DIV),
    .mag_a     (WIDTH'(abs_a)),
    .mag_b     (WIDTH'(abs_b)),
    .done      (core_done),
    .product   (product),
    .quotient  (quotient),
    .remainder (remainder)
  );

  // State register; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    start     = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          case (op)
            OP_MUL: begin
              state_nxt = BUSY;
              start     = 1'b1;
            end
            OP_DIV: begin
              if (b_zero) begin
                state_nxt = DONE;
              end else begin
                state_nxt = BUSY;
                start     = 1'b1;
              end
            end
            default: state_nxt = DONE;
          endcase
        end
      end
      BUSY: if (core_done) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Result/flag registers: single-cycle ops resolve on accept, iterative ops in FIX
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q     <= OP_ADD;
      neg_q    <= 1'b0;
      sa_q     <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      dz_q     <= 1'b0;
    end else if (accept) begin
      op_q  <= op;
      neg_q <= A[WIDTH-1] ^ B[WIDTH-1];
      sa_q  <= A[WIDTH-1];
      case (op)
        OP_MUL: begin
          ovf_q <= 1'b0;
          dz_q  <= 1'b0;
        end
        OP_DIV: begin
          if (b_zero) begin
            result_q <= {A, {WIDTH{1'b0}}};
            ovf_q    <= 1'b0;
            dz_q     <= 1'b1;
          end else begin
            ovf_q <= div_wrap;
            dz_q  <= 1'b0;
          end
        end
        default: begin
          result_q <= {{(WIDTH-1){sum_ext[WIDTH]}}, sum_ext};
          ovf_q    <= sum_ext[WIDTH] ^ sum_ext[WIDTH-1];
          dz_q     <= 1'b0;
        end
      endcase
    end else if (state == FIX) begin
      if (op_q == OP_MUL) result_q <= neg_q ? (~product + 1'b1) : product;
      else                result_q <= {rem_s, quo_s};
    end
  end

endmodule

// File: tb/tb_arith_unit_mc.sv
module tb_arith_unit_mc;

  localparam int W = 16;
  localparam longint MAXV = (64'sd1 <<< (W - 1)) - 1;
  localparam longint MINV = -(64'sd1 <<< (W - 1));

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   A = '0;
  logic [W-1:0]   B = '0;
  logic [1:0]     op = 2'b00;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [2*W-1:0] result;
  logic           ovf, dz;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  arith_unit_mc #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .ovf       (ovf),
    .dz        (dz)
  );

  // Reference: plain signed arithmetic on 64-bit integers. Returns {ovf, dz, result}.
  function automatic logic [2*W+1:0] model(input logic [1:0] o, input logic [W-1:0] au, input logic [W-1:0] bu);
    longint a, b, s, q, r;
    logic [2*W-1:0] res;
    logic v, z;
    a = longint'($signed(au));
    b = longint'($signed(bu));
    v = 1'b0;
    z = 1'b0;
    res = '0;
    case (o)
      2'b00, 2'b01: begin
        s = (o == 2'b00) ? a + b : a - b;
        res = s[2*W-1:0];
        v = (s > MAXV) || (s < MINV);
      end
      2'b10: begin
        s = a * b;
        res = s[2*W-1:0];
      end
      default: begin
        if (b == 0) begin
          z = 1'b1;
          res = {au, {W{1'b0}}};
        end else begin
          q = a / b;
          r = a % b;
          v = (q > MAXV);
          res = {r[W-1:0], q[W-1:0]};
        end
      end
    endcase
    return {v, z, res};
  endfunction

  function automatic int model_lat(input logic [1:0] o, input logic [W-1:0] bu);
    if (o == 2'b10 || (o == 2'b11 && bu != '0)) return W + 2;
    return 1;
  endfunction

  // Issue one operation, wait (bounded) for the result, capture it, then consume it.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output logic [2*W-1:0] res, output logic f_ovf,
                        output logic f_dz, output int ready_leak);
    @(negedge clk);
    op = o; A = a; B = b; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0; A = W'($urandom); B = W'($urandom); op = 2'($urandom);
    lat = 0;
    ready_leak = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!out_valid && in_ready) ready_leak++;
    end while (!out_valid && lat < 100);
    res = result;
    f_ovf = ovf;
    f_dz = dz;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (result !== '0) begin failures++; $display("FAIL reset_result got=%h want=0", result); end
    checks++; if ({ovf, dz} !== 2'b00) begin failures++; $display("FAIL reset_flags got=%b want=00", {ovf, dz}); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_add_sub();
    int lat, leak;
    logic [2*W-1:0] res;
    logic v, z;
    run_op(2'b00, 16'sd32767, 16'sd1, lat, res, v, z, leak);
    checks++; if (lat !== 1) begin failures++; $display("FAIL add_latency got=%0d want=1", lat); end
    checks++; if (res !== 32'h0000_8000) begin failures++; $display("FAIL add_result got=%h want=00008000", res); end
    checks++; if ({v, z} !== 2'b10) begin failures++; $display("FAIL add_flags got=%b want=10", {v, z}); end
    run_op(2'b01, 16'h8000, 16'sd1, lat, res, v, z, leak);
    checks++; if (res !== 32'hFFFF_7FFF) begin failures++; $display("FAIL sub_min_result got=%h want=ffff7fff", res); end
    checks++; if (v !== 1'b1) begin failures++; $display("FAIL sub_min_ovf got=%b want=1", v); end
  endtask

  task automatic test_mul();
    int lat, leak;
    logic [2*W-1:0] res;
    logic v, z;
    run_op(2'b10, -16'sd3, 16'sd7, lat, res, v, z, leak);
    checks++; if (lat !== W + 2) begin failures++; $display("FAIL mul_latency got=%0d want=%0d", lat, W + 2); end
    checks++; if (res !== 32'hFFFF_FFEB) begin failures++; $display("FAIL mul_result got=%h want=ffffffeb", res); end
    checks++; if ({v, z} !== 2'b00) begin failures++; $display("FAIL mul_flags got=%b want=00", {v, z}); end
    checks++; if (leak !== 0) begin failures++; $display("FAIL mul_in_ready_busy got=%0d cycles want=0", leak); end
    run_op(2'b10, 16'h8000, 16'h8000, lat, res, v, z, leak);
    checks++; if (res !== 32'h4000_0000) begin failures++; $display("FAIL mul_minmin got=%h want=40000000", res); end
  endtask

  task automatic test_div();
    int lat, leak;
    logic [2*W-1:0] res;
    logic v, z;
    run_op(2'b11, -16'sd7, 16'sd2, lat, res, v, z, leak);
    checks++; if (lat !== W + 2) begin failures++; $display("FAIL div_latency got=%0d want=%0d", lat, W + 2); end
    checks++; if (res !== 32'hFFFF_FFFD) begin failures++; $display("FAIL div_neg_result got=%h want=fffffffd", res); end
    run_op(2'b11, 16'sd7, -16'sd2, lat, res, v, z, leak);
    checks++; if (res !== 32'h0001_FFFD) begin failures++; $display("FAIL div_negb_result got=%h want=0001fffd", res); end
    run_op(2'b11, 16'h8000, 16'hFFFF, lat, res, v, z, leak);
    checks++; if (res !== 32'h0000_8000) begin failures++; $display("FAIL div_wrap_result got=%h want=00008000", res); end
    checks++; if ({v, z} !== 2'b10) begin failures++; $display("FAIL div_wrap_flags got=%b want=10", {v, z}); end
  endtask

  task automatic test_div_zero();
    int lat, leak;
    logic [2*W-1:0] res;
    logic v, z;
    run_op(2'b11, 16'sd5, 16'sd0, lat, res, v, z, leak);
    checks++; if (lat !== 1) begin failures++; $display("FAIL dz_latency got=%0d want=1", lat); end
    checks++; if (res !== 32'h0005_0000) begin failures++; $display("FAIL dz_result got=%h want=00050000", res); end
    checks++; if ({v, z} !== 2'b01) begin failures++; $display("FAIL dz_flags got=%b want=01", {v, z}); end
  endtask

  task automatic test_backpressure();
    int lat, leak;
    logic [2*W-1:0] res;
    logic v, z;
    @(negedge clk);
    op = 2'b01; A = 16'sd10; B = 16'sd3; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL hold_handshake cycle=%0d got vld=%b rdy=%b want vld=1 rdy=0", i, out_valid, in_ready); end
      checks++; if (result !== 32'h0000_0007) begin failures++; $display("FAIL hold_result cycle=%0d got=%h want=00000007", i, result); end
      in_valid = (i % 2 == 0);
      op = 2'b10; A = W'($urandom); B = W'($urandom);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL release_handshake got vld=%b rdy=%b want vld=0 rdy=1", out_valid, in_ready); end
    run_op(2'b00, 16'sd1, 16'sd1, lat, res, v, z, leak);
    checks++; if (lat !== 1 || res !== 32'h0000_0002) begin failures++; $display("FAIL after_hold_add got lat=%0d res=%h want lat=1 res=00000002", lat, res); end
  endtask

  task automatic test_random();
    int lat, leak;
    logic [2*W-1:0] res;
    logic v, z;
    logic [1:0] o;
    logic [W-1:0] a, b;
    logic [2*W+1:0] exp;
    for (int n = 0; n < 40; n++) begin
      o = 2'($urandom);
      case ($urandom_range(0, 5))
        0: a = 16'h8000;
        1: a = 16'h7FFF;
        2: a = 16'hFFFF;
        default: a = W'($urandom);
      endcase
      case ($urandom_range(0, 6))
        0: b = 16'h0000;
        1: b = 16'hFFFF;
        2: b = 16'h8000;
        3: b = W'($urandom_range(1, 9));
        default: b = W'($urandom);
      endcase
      exp = model(o, a, b);
      run_op(o, a, b, lat, res, v, z, leak);
      checks++;
      if ({v, z, res} !== exp || lat !== model_lat(o, b)) begin
        failures++;
        $display("FAIL random n=%0d op=%0d a=%h b=%h got ovf=%b dz=%b res=%h lat=%0d want ovf=%b dz=%b res=%h lat=%0d",
                 n, o, a, b, v, z, res, lat, exp[2*W+1], exp[2*W], exp[2*W-1:0], model_lat(o, b));
      end
    end
  endtask

  task automatic test_reset_mid_op();
    int lat, leak, seen;
    logic [2*W-1:0] res;
    logic v, z;
    run_op(2'b00, 16'sd20, 16'sd22, lat, res, v, z, leak);
    @(negedge clk);
    op = 2'b10; A = -16'sd3; B = 16'sd7; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midreset_out_valid got=%b want=0", out_valid); end
    checks++; if (result !== '0 || ovf !== 1'b0 || dz !== 1'b0) begin failures++; $display("FAIL midreset_outputs got res=%h ovf=%b dz=%b want 0", result, ovf, dz); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL midreset_in_ready got=%b want=1", in_ready); end
    seen = 0;
    for (int i = 0; i < W + 6; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL midreset_partial got=%0d valid cycles want=0", seen); end
    run_op(2'b00, 16'sd2, 16'sd2, lat, res, v, z, leak);
    checks++; if (res !== 32'h0000_0004 || lat !== 1) begin failures++; $display("FAIL midreset_add got res=%h lat=%0d want res=00000004 lat=1", res, lat); end
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_mul();
    test_div();
    test_div_zero();
    test_backpressure();
    test_random();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
